// File: rtl/jtframe_sdram_rfsh_sched_if.sv
// Bus between the refresh scheduler and the SDRAM host: tick, request/grant and command outputs.
interface jtframe_sdram_rfsh_sched_if #(
    parameter int unsigned CW = 6
);
    logic          start;
    logic          noreq;
    logic          bg;
    logic          br;
    logic          rfshing;
    logic          help;
    logic [3:0]    cmd;
    logic [12:0]   sdram_a;
    logic [CW-1:0] debt;

    modport master (
        input  start, noreq, bg,
        output br, rfshing, help, cmd, sdram_a, debt
    );

    modport slave (
        output start, noreq, bg,
        input  br, rfshing, help, cmd, sdram_a, debt
    );
endinterface

// File: rtl/jtframe_sdram_rfsh_sched.sv
// Opportunistic SDRAM refresh scheduler: accumulates refresh debt and pays it off with
// PRECHARGE-all + REFRESH bursts, forcing refresh once the debt crosses a high-water mark.
module jtframe_sdram_rfsh_sched #(
    parameter int unsigned CW       = 6,
    parameter int unsigned RFSHCNT  = 9,
    parameter bit          HF       = 1'b1,
    parameter int unsigned TRP      = 2,
    parameter int unsigned TRFC     = HF ? 7 : 4,
    parameter int unsigned MAXBURST = 4,
    parameter int unsigned HELP_HI  = 2 ** (CW - 1),
    parameter int unsigned HELP_LO  = 2 ** (CW - 2)
) (
    input logic                       clk,
    input logic                       rst,
    jtframe_sdram_rfsh_sched_if.master bus
);
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam int unsigned TMAX = (TRP > TRFC) ? TRP : TRFC;
    localparam int unsigned WW   = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;
    localparam int unsigned BW   = $clog2(MAXBURST + 1);
    localparam logic [CW:0] DEBT_MAX = {1'b0, {CW{1'b1}}};

    typedef enum logic [1:0] {StIdle, StPre, StRef} state_e;

    state_e        state_q, state_d;
    logic          br_q, br_d;
    logic          rfshing_q, rfshing_d;
    logic          help_q, help_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [CW-1:0] debt_q, debt_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          start_q;

    logic          start_edge, grant, issue, can_more;
    logic [CW:0]   debt_sum;

    always_comb begin
        start_edge = bus.start & ~start_q;
        grant      = (state_q == StIdle) && br_q && bus.bg;
        can_more   = (debt_q != '0) && (burst_q < BW'(MAXBURST)) && (bus.noreq || help_q);

        state_d   = state_q;
        cmd_d     = CMD_NOP;
        wait_d    = wait_q;
        burst_d   = burst_q;
        rfshing_d = rfshing_q;
        issue     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    rfshing_d = 1'b1;
                    cmd_d     = CMD_PRE;
                    wait_d    = WW'(TRP - 1);
                    burst_d   = '0;
                    state_d   = StPre;
                end
            end
            StPre: begin
                if (wait_q == '0) issue = 1'b1;
                else              wait_d = wait_q - 1'b1;
            end
            StRef: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (can_more) begin
                    issue = 1'b1;
                end else begin
                    rfshing_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            cmd_d   = CMD_REF;
            burst_d = burst_q + 1'b1;
            wait_d  = WW'(TRFC - 1);
            state_d = StRef;
        end

        br_d = (state_q == StIdle) && (debt_q != '0) && (help_q || bus.noreq) && !grant;

        // One extra bit catches the overflow before saturating
        debt_sum = {1'b0, debt_q}
                 + (start_edge ? (CW + 1)'(RFSHCNT) : '0)
                 - ((issue && debt_q != '0) ? (CW + 1)'(1) : '0);
        debt_d   = (debt_sum > DEBT_MAX) ? DEBT_MAX[CW-1:0] : debt_sum[CW-1:0];

        help_d = help_q;
        if (debt_d >= CW'(HELP_HI))      help_d = 1'b1;
        else if (debt_d <= CW'(HELP_LO)) help_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            br_q      <= 1'b0;
            rfshing_q <= 1'b0;
            help_q    <= 1'b0;
            cmd_q     <= CMD_NOP;
            debt_q    <= '0;
            burst_q   <= '0;
            wait_q    <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            rfshing_q <= rfshing_d;
            help_q    <= help_d;
            cmd_q     <= cmd_d;
            debt_q    <= debt_d;
            burst_q   <= burst_d;
            wait_q    <= wait_d;
            start_q   <= bus.start;
        end
    end

    assign bus.br      = br_q;
    assign bus.rfshing = rfshing_q;
    assign bus.help    = help_q;
    assign bus.cmd     = cmd_q;
    assign bus.debt    = debt_q;
    assign bus.sdram_a = 13'h400;
endmodule

// File: tb/tb_jtframe_sdram_rfsh_sched.sv
// Directed bench for jtframe_sdram_rfsh_sched: expected commands are queued by the stimulus
// and a negedge monitor matches them, including spacing between commands.
module tb_jtframe_sdram_rfsh_sched;
    localparam int unsigned CW       = 6;
    localparam int unsigned RFSHCNT  = 3;
    localparam int unsigned TRP      = 2;
    localparam int unsigned TRFC     = 7;
    localparam int unsigned MAXBURST = 4;
    localparam int unsigned HELP_HI  = 16;
    localparam int unsigned HELP_LO  = 4;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

    typedef struct {
        logic [3:0] cmd;
        int         debt;
        int         gap;   // cycles since previous command, -1 = unchecked
    } exp_t;

    logic clk;
    logic rst;
    logic bg_en;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    jtframe_sdram_rfsh_sched_if #(.CW(CW)) bus ();

    jtframe_sdram_rfsh_sched #(
        .CW      (CW),
        .RFSHCNT (RFSHCNT),
        .HF      (1'b1),
        .TRP     (TRP),
        .TRFC    (TRFC),
        .MAXBURST(MAXBURST),
        .HELP_HI (HELP_HI),
        .HELP_LO (HELP_LO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input logic [3:0] c, input int d, input int g);
        exp_t e;
        e.cmd  = c;
        e.debt = d;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc_wait(1);
        bus.start = 1'b0;
        cyc_wait(1);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.rfshing || bus.br) && n < budget) begin
            cyc_wait(1);
            n++;
        end
        chk(name, int'(n < budget), 1);
    endtask

    task automatic wait_cmd(input string name, input logic [3:0] c, input int budget);
        int n = 0;
        while (bus.cmd != c && n < budget) begin
            cyc_wait(1);
            n++;
        end
        chk(name, int'(n < budget), 1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_br"}, int'(bus.br), 0);
        chk({tag, "_rfshing"}, int'(bus.rfshing), 0);
        chk({tag, "_help"}, int'(bus.help), 0);
        chk({tag, "_cmd"}, int'(bus.cmd), int'(NOP));
        chk({tag, "_debt"}, int'(bus.debt), 0);
        chk({tag, "_sdram_a"}, int'(bus.sdram_a), 'h400);
    endtask

    // Grant follows the request one cycle late, gated by bg_en
    initial begin : bg_drv
        logic br_prev;
        br_prev = 1'b0;
        bus.bg  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.bg  = bg_en & br_prev;
            br_prev = bus.br;
        end
    end

    initial begin : monitor
        int   last_cmd_cyc;
        logic prev_rf;
        exp_t e;
        last_cmd_cyc = 0;
        prev_rf      = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_rf = 1'b0;
                continue;
            end
            if (bus.cmd != NOP) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", int'(bus.cmd), int'(NOP));
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", int'(bus.cmd), int'(e.cmd));
                    chk("cmd_debt", int'(bus.debt), e.debt);
                    chk("cmd_rfshing", int'(bus.rfshing), 1);
                    if (e.gap >= 0) chk("cmd_gap", cyc - last_cmd_cyc, e.gap);
                end
                last_cmd_cyc = cyc;
            end
            if (prev_rf && !bus.rfshing) chk("rfshing_fall_gap", cyc - last_cmd_cyc, TRFC);
            prev_rf = bus.rfshing;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int d;
        int k;
        bit h;

        rst       = 1'b1;
        bg_en     = 1'b1;
        bus.start = 1'b0;
        bus.noreq = 1'b1;
        cyc_wait(2);
        chk_reset_values("reset");
        rst = 1'b0;
        cyc_wait(2);

        // Single tick, idle host: three refreshes then release
        push(PRE, 3, -1);
        push(REF, 2, TRP);
        push(REF, 1, TRFC);
        push(REF, 0, TRFC);
        pulse_start();
        chk("single_br_up", int'(bus.br), 1);
        drain("single_drain", 100);
        chk("single_debt", int'(bus.debt), 0);
        chk("single_br_low", int'(bus.br), 0);

        // Busy host: nothing happens until help, then bursts until help clears
        bus.noreq = 1'b0;
        d = 18;
        h = 1'b1;
        while (d > 0 && h) begin
            push(PRE, d, -1);
            k = 0;
            do begin
                d--;
                push(REF, d, (k == 0) ? TRP : TRFC);
                k++;
                if (d <= HELP_LO) h = 1'b0;
            end while (k < MAXBURST && d > 0 && h);
        end
        for (int i = 0; i < 6; i++) begin
            pulse_start();
            chk("busy_debt", int'(bus.debt), 3 * (i + 1));
            chk("busy_br", int'(bus.br), int'(i == 5));
        end
        chk("busy_help_set", int'(bus.help), 1);
        drain("busy_drain", 400);
        // help drops when debt reaches 4, so the last burst stops there
        chk("busy_debt_left", int'(bus.debt), 4);
        chk("busy_help_clr", int'(bus.help), 0);
        cyc_wait(5);
        chk("busy_br_held", int'(bus.br), 0);
        chk("busy_debt_held", int'(bus.debt), 4);

        push(PRE, 4, -1);
        push(REF, 3, TRP);
        push(REF, 2, TRFC);
        push(REF, 1, TRFC);
        push(REF, 0, TRFC);
        bus.noreq = 1'b1;
        drain("cleanup_drain", 100);
        chk("cleanup_debt", int'(bus.debt), 0);

        // Saturation with grant withheld, then reset in the middle of a REF wait
        bg_en = 1'b0;
        for (int i = 0; i < 25; i++) begin
            pulse_start();
            if (i == 19) chk("sat_debt_60", int'(bus.debt), 60);
        end
        chk("sat_debt_63", int'(bus.debt), 63);
        chk("sat_help", int'(bus.help), 1);
        push(PRE, 63, -1);
        push(REF, 62, TRP);
        bg_en = 1'b1;
        wait_cmd("sat_first_ref", REF, 30);
        cyc_wait(2);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_values("midref_reset");
        rst = 1'b0;
        cyc_wait(3);
        chk("post_reset_debt", int'(bus.debt), 0);
        chk("post_reset_cmd", int'(bus.cmd), int'(NOP));

        // Tick lands on the same edge as a REFRESH: 5 + 3 - 1
        bg_en = 1'b0;
        push(PRE, 6, -1);
        push(REF, 5, TRP);
        push(REF, 7, TRFC);
        push(REF, 6, TRFC);
        push(REF, 5, TRFC);
        push(PRE, 5, -1);
        push(REF, 4, TRP);
        push(REF, 3, TRFC);
        push(REF, 2, TRFC);
        push(REF, 1, TRFC);
        push(PRE, 1, -1);
        push(REF, 0, TRP);
        pulse_start();
        pulse_start();
        chk("coinc_debt_6", int'(bus.debt), 6);
        bg_en = 1'b1;
        wait_cmd("coinc_first_ref", REF, 30);
        chk("coinc_debt_5", int'(bus.debt), 5);
        cyc_wait(TRFC - 1);
        bus.start = 1'b1;
        cyc_wait(1);
        bus.start = 1'b0;
        chk("coinc_debt_7", int'(bus.debt), 7);
        drain("coinc_drain", 200);
        chk("coinc_debt_end", int'(bus.debt), 0);

        // Request withdrawn before grant
        pulse_start();
        chk("withdraw_br_up", int'(bus.br), 1);
        bus.noreq = 1'b0;
        cyc_wait(1);
        chk("withdraw_br_low", int'(bus.br), 0);
        chk("withdraw_debt", int'(bus.debt), 3);
        cyc_wait(10);
        chk("withdraw_debt_held", int'(bus.debt), 3);
        chk("withdraw_rfshing", int'(bus.rfshing), 0);
        push(PRE, 3, -1);
        push(REF, 2, TRP);
        push(REF, 1, TRFC);
        push(REF, 0, TRFC);
        bus.noreq = 1'b1;
        drain("withdraw_drain", 100);
        chk("withdraw_debt_end", int'(bus.debt), 0);

        cyc_wait(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
